// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester and UART byte-engine signals shared by the transmit arbiter
// Requester side: req_valid/req_data/req_last in, req_ready out (one-cycle accept pulse).
// Engine side: tx_data_en/tx_data out to the engine, tx_start/tx_busy back from it.
// master drives requests and engine responses; slave is the arbiter.
interface uart_tx_arbiter_if #(
   parameter int N_REQ = 4
);
   logic [N_REQ-1:0]   req_valid;
   logic [8*N_REQ-1:0] req_data;
   logic [N_REQ-1:0]   req_last;
   logic [N_REQ-1:0]   req_ready;
   logic               tx_data_en;
   logic [7:0]         tx_data;
   logic               tx_start;
   logic               tx_busy;
   modport master (
      output req_valid, req_data, req_last, tx_start, tx_busy,
      input  req_ready, tx_data_en, tx_data
   );
   modport slave (
      input  req_valid, req_data, req_last, tx_start, tx_busy,
      output req_ready, tx_data_en, tx_data
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, frame-locking scheduler sharing one UART transmit engine
// Ports: clk; rst_n (async, active low); bus (slave) carries requester valid/data/last/ready
// and engine tx_data_en/tx_data/tx_start/tx_busy; grant_id = current/last grant,
// locked = frame in progress, err_timeout = one-cycle pulse when tx_start never arrives.
module uart_tx_arbiter #(
   parameter int N_REQ    = 4,
   parameter int START_TO = 255
) (
   input  logic                     clk,
   input  logic                     rst_n,
   uart_tx_arbiter_if.slave         bus,
   output logic [$clog2(N_REQ)-1:0] grant_id,
   output logic                     locked,
   output logic                     err_timeout
);
   localparam int W = $clog2(N_REQ);
   typedef enum logic [1:0] {IDLE, LOAD, START, DRAIN} state_t;
   state_t state, state_d;
   logic [W-1:0] rr_ptr, rr_ptr_d, grant_d, pick, idx, next_id;
   logic [N_REQ-1:0] ready_d;
   logic [15:0] cnt, cnt_d;
   logic [7:0] data_d;
   logic found, locked_d, last_q, last_d, busy_seen, busy_seen_d, en_d, err_d;

   assign next_id = (grant_id == W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;

   // scan offsets from far to near so the requester closest above rr_ptr overwrites the rest
   always_comb begin
      pick = '0;
      idx = '0;
      found = 1'b0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         idx = W'((int'(rr_ptr) + k) % N_REQ);
         if (bus.req_valid[idx]) begin
            pick = idx;
            found = 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state;
      grant_d = grant_id;
      locked_d = locked;
      rr_ptr_d = rr_ptr;
      last_d = last_q;
      busy_seen_d = busy_seen;
      cnt_d = cnt;
      en_d = bus.tx_data_en;
      data_d = bus.tx_data;
      ready_d = '0;
      err_d = 1'b0;
      case (state)
         // holding off while tx_busy covers an engine frame begun before a reset
         IDLE: if (!bus.tx_busy) begin
            if (locked && bus.req_valid[grant_id]) begin
               ready_d[grant_id] = 1'b1;
               state_d = LOAD;
            end else if (!locked && found) begin
               grant_d = pick;
               locked_d = 1'b1;
               ready_d[pick] = 1'b1;
               state_d = LOAD;
            end
         end
         LOAD: begin
            data_d = bus.req_data[{grant_id, 3'b000} +: 8];
            last_d = bus.req_last[grant_id];
            en_d = 1'b1;
            cnt_d = '0;
            state_d = START;
         end
         START: if (bus.tx_start) begin
            en_d = 1'b0;
            busy_seen_d = 1'b0;
            state_d = DRAIN;
         end else if (cnt == 16'(START_TO - 1)) begin
            en_d = 1'b0;
            err_d = 1'b1;
            locked_d = 1'b0;
            rr_ptr_d = next_id;
            state_d = IDLE;
         end else begin
            cnt_d = cnt + 1'b1;
         end
         DRAIN: if (bus.tx_busy) begin
            busy_seen_d = 1'b1;
         end else if (busy_seen) begin
            locked_d = last_q ? 1'b0 : locked;
            rr_ptr_d = last_q ? next_id : rr_ptr;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         bus.tx_data_en <= 1'b0;
         bus.tx_data <= '0;
         bus.req_ready <= '0;
         grant_id <= '0;
         rr_ptr <= '0;
         locked <= 1'b0;
         err_timeout <= 1'b0;
         last_q <= 1'b0;
         busy_seen <= 1'b0;
         cnt <= '0;
      end else begin
         state <= state_d;
         bus.tx_data_en <= en_d;
         bus.tx_data <= data_d;
         bus.req_ready <= ready_d;
         grant_id <= grant_d;
         rr_ptr <= rr_ptr_d;
         locked <= locked_d;
         err_timeout <= err_d;
         last_q <= last_d;
         busy_seen <= busy_seen_d;
         cnt <= cnt_d;
      end
   end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed bench with requester FIFOs, a UART engine stub and a bus monitor
module tb_uart_tx_arbiter;
   localparam int N = 4;
   localparam int FRAME = 12;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic [1:0] grant_id;
   logic locked, err_timeout;
   uart_tx_arbiter_if #(.N_REQ(N)) bus();
   uart_tx_arbiter #(.N_REQ(N), .START_TO(8)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus),
      .grant_id(grant_id), .locked(locked), .err_timeout(err_timeout)
   );
   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   logic [8:0] fifo [N][32];
   int head [N];
   int tail [N];
   bit adv [N];
   bit stub_on = 1'b1;
   logic [7:0] sent [$];
   int grants [$];
   int err_cnt = 0, en_run = 0, en_len_last = 0, low_run = 0, min_gap = 1000;
   int cyc = 0, t_fall = 0, ready_gap = 0, multi_ready = 0;
   logic busy_prev = 1'b0;

   task automatic push(input int i, input logic last, input logic [7:0] d);
      fifo[i][tail[i] % 32] = {last, d};
      tail[i]++;
   endtask

   // requesters: present FIFO heads, pop one cycle after the accept pulse was seen
   initial begin
      for (int i = 0; i < N; i++) begin
         head[i] = 0;
         tail[i] = 0;
         adv[i] = 1'b0;
      end
      bus.req_valid = '0;
      bus.req_data = '0;
      bus.req_last = '0;
      forever begin
         @(negedge clk);
         #1;
         for (int i = 0; i < N; i++) begin
            if (adv[i]) head[i]++;
            adv[i] = bus.req_ready[i];
            bus.req_valid[i] = head[i] != tail[i];
            bus.req_data[8*i +: 8] = fifo[i][head[i] % 32][7:0];
            bus.req_last[i] = fifo[i][head[i] % 32][8];
         end
      end
   end

   // engine stub: tx_start one cycle after an en rising edge, then tx_busy for FRAME cycles
   initial begin
      bit pend, en_prev;
      int left;
      pend = 1'b0;
      en_prev = 1'b0;
      left = 0;
      bus.tx_start = 1'b0;
      bus.tx_busy = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         bus.tx_start = pend;
         if (pend) left = FRAME;
         else if (left > 0) begin
            bus.tx_busy = 1'b1;
            left--;
         end else bus.tx_busy = 1'b0;
         pend = stub_on && bus.tx_data_en && !en_prev;
         en_prev = bus.tx_data_en;
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #3;
         cyc++;
         if ($countones(bus.req_ready) > 1) multi_ready++;
         for (int i = 0; i < N; i++)
            if (bus.req_ready[i]) begin
               grants.push_back(i);
               ready_gap = cyc - t_fall;
            end
         if (bus.tx_start && bus.tx_data_en) sent.push_back(bus.tx_data);
         if (err_timeout) err_cnt++;
         if (busy_prev && !bus.tx_busy) t_fall = cyc;
         busy_prev = bus.tx_busy;
         if (bus.tx_data_en) begin
            if (en_run == 0 && low_run > 0 && low_run < min_gap) min_gap = low_run;
            en_run++;
            low_run = 0;
         end else begin
            if (en_run > 0) en_len_last = en_run;
            en_run = 0;
            low_run++;
         end
      end
   end

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      vectors++; if (bus.tx_data_en !== 1'b0) begin miscompares++; $display("FAIL reset_en got %b want 0", bus.tx_data_en); end
      vectors++; if (bus.tx_data !== 8'h00) begin miscompares++; $display("FAIL reset_data got %h want 00", bus.tx_data); end
      vectors++; if (bus.req_ready !== 4'b0000) begin miscompares++; $display("FAIL reset_ready got %b want 0000", bus.req_ready); end
      vectors++; if (grant_id !== 2'd0) begin miscompares++; $display("FAIL reset_grant got %0d want 0", grant_id); end
      vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL reset_locked got %b want 0", locked); end
      vectors++; if (err_timeout !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b want 0", err_timeout); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single();
      sent.delete();
      @(negedge clk);
      push(0, 1'b1, 8'hA5);
      @(negedge clk);
      vectors++; if (bus.req_ready !== 4'b0001) begin miscompares++; $display("FAIL single_ready got %b want 0001", bus.req_ready); end
      vectors++; if (locked !== 1'b1 || grant_id !== 2'd0) begin miscompares++; $display("FAIL single_grant got locked=%b id=%0d want 1/0", locked, grant_id); end
      vectors++; if (bus.tx_data_en !== 1'b0) begin miscompares++; $display("FAIL single_en_early got %b want 0", bus.tx_data_en); end
      @(negedge clk);
      vectors++; if (bus.tx_data_en !== 1'b1 || bus.tx_data !== 8'hA5) begin miscompares++; $display("FAIL single_en got en=%b data=%h want 1/a5", bus.tx_data_en, bus.tx_data); end
      vectors++; if (bus.req_ready !== 4'b0000) begin miscompares++; $display("FAIL single_ready_pulse got %b want 0000", bus.req_ready); end
      for (int n = 0; n < 60 && locked; n++) @(negedge clk);
      vectors++; if (locked !== 1'b0 || bus.tx_busy !== 1'b0) begin miscompares++; $display("FAIL single_unlock got locked=%b busy=%b want 0/0", locked, bus.tx_busy); end
      vectors++; if (en_len_last != 2) begin miscompares++; $display("FAIL single_en_len got %0d want 2", en_len_last); end
      vectors++; if (sent.size() != 1 || sent[0] !== 8'hA5) begin miscompares++; $display("FAIL single_sent got %0d bytes want 1 byte a5", sent.size()); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp_b [4] = '{8'h11, 8'h22, 8'h33, 8'h99};
      int exp_g [4] = '{1, 1, 1, 2};
      logic [7:0] got;
      int gg;
      sent.delete();
      grants.delete();
      multi_ready = 0;
      @(negedge clk);
      push(1, 1'b0, 8'h11);
      push(1, 1'b0, 8'h22);
      push(1, 1'b1, 8'h33);
      push(2, 1'b1, 8'h99);
      for (int n = 0; n < 300 && !(sent.size() >= 4 && !locked); n++) @(negedge clk);
      vectors++; if (sent.size() < 4 || locked) begin miscompares++; $display("FAIL b2b_done got %0d bytes locked=%b want 4/0", sent.size(), locked); end
      for (int k = 0; k < 4; k++) begin
         got = (k < sent.size()) ? sent[k] : 8'h00;
         gg = (k < grants.size()) ? grants[k] : -1;
         vectors++; if (got !== exp_b[k]) begin miscompares++; $display("FAIL b2b_byte%0d got %h want %h", k, got, exp_b[k]); end
         vectors++; if (gg != exp_g[k]) begin miscompares++; $display("FAIL b2b_grant%0d got %0d want %0d", k, gg, exp_g[k]); end
      end
      vectors++; if (ready_gap != 2) begin miscompares++; $display("FAIL b2b_load_gap got %0d want 2", ready_gap); end
      vectors++; if (multi_ready != 0) begin miscompares++; $display("FAIL b2b_onehot got %0d multi-ready cycles want 0", multi_ready); end
   endtask

   task automatic test_round_robin();
      logic [7:0] got;
      int gg;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      sent.delete();
      grants.delete();
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         push(i, 1'b1, 8'h40 + 8'(i));
         push(i, 1'b1, 8'h50 + 8'(i));
      end
      for (int n = 0; n < 500 && !(sent.size() >= 8 && !locked); n++) @(negedge clk);
      vectors++; if (sent.size() != 8) begin miscompares++; $display("FAIL rr_count got %0d want 8", sent.size()); end
      for (int k = 0; k < 8; k++) begin
         got = (k < sent.size()) ? sent[k] : 8'h00;
         gg = (k < grants.size()) ? grants[k] : -1;
         vectors++; if (gg != k % 4) begin miscompares++; $display("FAIL rr_grant%0d got %0d want %0d", k, gg, k % 4); end
         vectors++; if (got !== ((k < 4) ? 8'h40 + 8'(k) : 8'h50 + 8'(k - 4))) begin miscompares++; $display("FAIL rr_byte%0d got %h", k, got); end
      end
   endtask

   task automatic test_timeout();
      bit seen;
      sent.delete();
      grants.delete();
      err_cnt = 0;
      min_gap = 1000;
      seen = 1'b0;
      @(negedge clk);
      stub_on = 1'b0;
      push(0, 1'b1, 8'h77);
      push(2, 1'b1, 8'h88);
      for (int n = 0; n < 40 && !seen; n++) begin
         @(negedge clk);
         seen = err_timeout;
      end
      vectors++; if (!seen) begin miscompares++; $display("FAIL to_err got no pulse want pulse"); end
      vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL to_unlock got %b want 0", locked); end
      vectors++; if (en_len_last != 8) begin miscompares++; $display("FAIL to_en_len got %0d want 8", en_len_last); end
      stub_on = 1'b1;
      for (int n = 0; n < 60 && !(sent.size() >= 1 && !locked); n++) @(negedge clk);
      vectors++; if (sent.size() != 1 || sent[0] !== 8'h88) begin miscompares++; $display("FAIL to_next_byte got %0d bytes want 1 byte 88", sent.size()); end
      vectors++; if (grants.size() != 2 || grants[1] != 2) begin miscompares++; $display("FAIL to_next_grant got %0d grants want 0 then 2", grants.size()); end
      vectors++; if (err_cnt != 1) begin miscompares++; $display("FAIL to_err_count got %0d want 1", err_cnt); end
      vectors++; if (min_gap != 2) begin miscompares++; $display("FAIL to_en_gap got %0d want 2", min_gap); end
   endtask

   task automatic test_reset_mid_frame();
      bit en_seen;
      sent.delete();
      @(negedge clk);
      push(1, 1'b0, 8'hA1);
      push(1, 1'b0, 8'hA2);
      push(1, 1'b1, 8'hA3);
      for (int n = 0; n < 100 && !(sent.size() >= 2 && bus.tx_busy); n++) @(negedge clk);
      vectors++; if (sent.size() != 2 || !bus.tx_busy) begin miscompares++; $display("FAIL rst_setup got %0d bytes busy=%b want 2/1", sent.size(), bus.tx_busy); end
      rst_n = 1'b0;
      head[1] = tail[1];
      #1;
      vectors++; if (bus.tx_data_en !== 1'b0 || bus.tx_data !== 8'h00 || bus.req_ready !== 4'b0000) begin miscompares++; $display("FAIL rst_async_bus got en=%b data=%h ready=%b want 0/00/0000", bus.tx_data_en, bus.tx_data, bus.req_ready); end
      vectors++; if (grant_id !== 2'd0 || locked !== 1'b0 || err_timeout !== 1'b0) begin miscompares++; $display("FAIL rst_async_status got id=%0d locked=%b err=%b want 0/0/0", grant_id, locked, err_timeout); end
      sent.delete();
      grants.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      en_seen = 1'b0;
      repeat (3) begin
         @(negedge clk);
         en_seen |= bus.tx_data_en;
      end
      vectors++; if (en_seen) begin miscompares++; $display("FAIL rst_no_restart got en=1 want 0"); end
      push(1, 1'b1, 8'hC3);
      for (int n = 0; n < 30 && bus.tx_busy; n++) begin
         @(negedge clk);
         en_seen |= bus.tx_data_en && bus.tx_busy;
      end
      vectors++; if (en_seen || bus.tx_busy) begin miscompares++; $display("FAIL rst_wait_busy got en_during_busy=%b busy=%b want 0/0", en_seen, bus.tx_busy); end
      for (int n = 0; n < 60 && !(sent.size() >= 1 && !locked); n++) @(negedge clk);
      vectors++; if (sent.size() != 1 || sent[0] !== 8'hC3) begin miscompares++; $display("FAIL rst_new_frame got %0d bytes want 1 byte c3", sent.size()); end
      vectors++; if (grant_id !== 2'd1) begin miscompares++; $display("FAIL rst_new_grant got %0d want 1", grant_id); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_round_robin();
      test_timeout();
      test_reset_mid_frame();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end
endmodule
